// File: rtl/clken_gen.sv
// Multi-channel rational clock-enable generator. Each channel emits NUM_i
// one-cycle enables per DEN_i master cycles from a drift-free phase accumulator.
module clken_gen #(
    parameter int                        CHANNELS    = 3,
    parameter int                        ACC_W       = 16,
    parameter logic [CHANNELS*ACC_W-1:0] NUM         = {16'd1, 16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_W-1:0] DEN         = {16'd12, 16'd4, 16'd1},
    parameter int                        LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] run,
    input  logic                resync,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);

    localparam int             LCW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_CYCLES);

    logic [LCW-1:0] lock_cnt;

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("clken_gen: CHANNELS must be in 1..8");
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
            if (lock_cnt == LOCK_LAST) begin
                locked <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [ACC_W-1:0] N = NUM[i*ACC_W +: ACC_W];
        localparam logic [ACC_W-1:0] D = DEN[i*ACC_W +: ACC_W];

        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             pulse;

        if (N == '0 || N > D) begin : g_bad_ratio
            $error("clken_gen: channel %0d needs 0 < NUM <= DEN", i);
        end

        // One extra bit so the wrap test cannot overflow before comparing to DEN.
        assign sum = {1'b0, acc} + {1'b0, N};

        always_ff @(posedge refclk) begin
            if (rst || !locked || resync) begin
                acc   <= '0;
                pulse <= 1'b0;
            end else if (run[i]) begin
                if (sum >= {1'b0, D}) begin
                    acc   <= ACC_W'(sum - {1'b0, D});
                    pulse <= 1'b1;
                end else begin
                    acc   <= sum[ACC_W-1:0];
                    pulse <= 1'b0;
                end
            end else begin
                pulse <= 1'b0;
            end
        end

        assign ce[i] = pulse;
    end

endmodule

// File: tb/tb_clken_gen.sv
// Scoreboard bench for clken_gen: a default-ratio instance and a 3/8 fractional
// instance share stimulus; a pulse-counting reference model predicts every cycle.
module tb_clken_gen;

    localparam int          LOCK  = 16;
    localparam logic [47:0] NUM_A = {16'd1, 16'd1, 16'd1};
    localparam logic [47:0] DEN_A = {16'd12, 16'd4, 16'd1};
    localparam logic [47:0] NUM_B = {16'd1, 16'd3, 16'd1};
    localparam logic [47:0] DEN_B = {16'd12, 16'd8, 16'd1};

    logic       refclk = 1'b0;
    logic       rst;
    logic       resync;
    logic [2:0] run;
    logic [2:0] ce_a, ce_b;
    logic       locked_a, locked_b;

    clken_gen #(.CHANNELS(3), .ACC_W(16), .NUM(NUM_A), .DEN(DEN_A), .LOCK_CYCLES(LOCK)) dut_a (
        .refclk(refclk), .rst(rst), .run(run), .resync(resync), .ce(ce_a), .locked(locked_a)
    );

    clken_gen #(.CHANNELS(3), .ACC_W(16), .NUM(NUM_B), .DEN(DEN_B), .LOCK_CYCLES(LOCK)) dut_b (
        .refclk(refclk), .rst(rst), .run(run), .resync(resync), .ce(ce_b), .locked(locked_b)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       locked;
        logic [5:0] ce;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Channels 0..2 belong to dut_a, 3..5 to dut_b.
    int m_num[6] = '{1, 1, 1, 1, 3, 1};
    int m_den[6] = '{1, 4, 12, 1, 8, 12};

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic rs, input logic rt);
        run    = r;
        resync = rs;
        rst    = rt;
        @(posedge refclk);
        #1;
    endtask

    // Reference model: a channel pulses on its n-th enabled cycle since phase zero
    // exactly when floor(n*NUM/DEN) steps up.
    initial begin
        int   phase[6];
        int   edges;
        bit   mlocked;
        exp_t e;
        edges   = 0;
        mlocked = 1'b0;
        foreach (phase[c]) phase[c] = 0;
        forever begin
            @(posedge refclk);
            e = '0;
            if (rst) begin
                edges   = 0;
                mlocked = 1'b0;
                foreach (phase[c]) phase[c] = 0;
            end else begin
                for (int c = 0; c < 6; c++) begin
                    if (mlocked && !resync && run[c % 3]) begin
                        phase[c]++;
                        e.ce[c] = ((phase[c] * m_num[c]) / m_den[c]) != (((phase[c] - 1) * m_num[c]) / m_den[c]);
                        if (phase[c] == m_den[c]) phase[c] = 0;
                    end else if (!mlocked || resync) begin
                        phase[c] = 0;
                    end
                end
                if (edges < LOCK) edges++;
                mlocked = (edges >= LOCK);
            end
            e.locked = mlocked;
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_ce_a", ce_a, e.ce[2:0]);
                checkOutput("sb_ce_b", ce_b, e.ce[5:3]);
                checkOutput("sb_locked", {locked_a, locked_b}, {e.locked, e.locked});
            end
        end
    end

    initial begin
        int cnt_a[3];
        int cnt_b1;
        int gated;
        int gap;
        int ch1_hits;
        int ch2_first;
        logic [2:0] r;

        foreach (cnt_a[c]) cnt_a[c] = 0;
        cnt_b1 = 0;
        $display("[TB] reset and lock");
        for (int k = 0; k < 3; k++) applyStimulus(3'b111, 1'b0, 1'b1);
        checkOutput("reset_locked", locked_a, 0);
        checkOutput("reset_ce", ce_a, 0);

        for (int k = 1; k <= LOCK; k++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            if (k == LOCK - 1) checkOutput("locked_edge15", locked_a, 0);
            if (k == LOCK) begin
                checkOutput("locked_edge16", locked_a, 1);
                checkOutput("ce_at_lock", ce_a, 0);
            end
        end

        $display("[TB] steady rates");
        for (int k = 1; k <= 1200; k++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            for (int c = 0; c < 3; c++) cnt_a[c] += int'(ce_a[c]);
            if (k <= 800) cnt_b1 += int'(ce_b[1]);
        end
        checkOutput("rate_ch0", cnt_a[0], 1200);
        checkOutput("rate_ch1", cnt_a[1], 300);
        checkOutput("rate_ch2", cnt_a[2], 100);
        checkOutput("rate_frac_3_8", cnt_b1, 300);

        $display("[TB] run gating");
        applyStimulus(3'b111, 1'b0, 1'b0);
        applyStimulus(3'b111, 1'b0, 1'b0);
        gated = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'b101, 1'b0, 1'b0);
            gated += int'(ce_a[1]);
        end
        checkOutput("gated_ch1_pulses", gated, 0);
        gap = 0;
        for (int k = 1; k <= 8 && gap == 0; k++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            if (ce_a[1]) gap = k;
        end
        checkOutput("resume_gap", gap, 2);

        $display("[TB] resync");
        applyStimulus(3'b111, 1'b0, 1'b0);
        applyStimulus(3'b111, 1'b1, 1'b0);
        checkOutput("resync_ce_a", ce_a, 0);
        checkOutput("resync_ce_b", ce_b, 0);
        ch1_hits  = 0;
        ch2_first = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            if (ce_a[1]) ch1_hits += k;
            if (ce_a[2] && ch2_first == 0) ch2_first = k;
        end
        checkOutput("resync_ch1_edges_sum", ch1_hits, 4 + 8 + 12);
        checkOutput("resync_ch2_first", ch2_first, 12);

        $display("[TB] mid-run reset");
        applyStimulus(3'b111, 1'b0, 1'b1);
        checkOutput("midrst_locked", locked_a, 0);
        checkOutput("midrst_ce", ce_a, 0);
        for (int k = 1; k <= LOCK; k++) applyStimulus(3'b111, 1'b0, 1'b0);
        checkOutput("relock", locked_a, 1);
        gap = 0;
        for (int k = 1; k <= 10 && gap == 0; k++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            if (ce_a[1]) gap = k;
        end
        checkOutput("relock_ch1_first", gap, 4);

        $display("[TB] random traffic");
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < 3; c++) r[c] = ($urandom_range(0, 9) < 8);
            applyStimulus(r, ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
        end
        for (int k = 0; k < 4; k++) applyStimulus(3'b111, 1'b0, 1'b0);

        @(negedge refclk);
        #1;
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
